// File: rtl/reg_file_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     i_rd_addr,
  output logic [NUM_RD*XLEN-1:0]   o_rd_dat,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*AW-1:0]     i_wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   i_wr_dat,
  input  logic                     i_alloc_en,
  input  logic [AW-1:0]            i_alloc_addr,
  output logic [NREG-1:0]          o_busy_vec
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Entry 0 and out-of-range addresses are never written, read or allocated.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != {AW{1'b0}}) && (32'(a) < NREG);
  endfunction

  // Next state: ascending port scan lets the highest-index writer win; alloc applied last.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      for (int r = 1; r < NREG; r++) begin
        if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] == AW'(r))) begin
          regs_d[r]  = i_wr_dat[w*XLEN +: XLEN];
          busy_d[r]  = 1'b0;
        end else begin
          regs_d[r]  = regs_d[r];
          busy_d[r]  = busy_d[r];
        end
      end
    end
    for (int r = 1; r < NREG; r++) begin
      if (i_alloc_en && (i_alloc_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else begin
        busy_d[r] = busy_d[r];
      end
    end
    regs_d[0] = {XLEN{1'b0}};
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= {XLEN{1'b0}};
      end
      busy_q <= {NREG{1'b0}};
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports: registered state, optionally overridden by same-cycle writes.
  always_comb begin
    o_rd_dat  = {(NUM_RD*XLEN){1'b0}};
    o_rd_busy = {NUM_RD{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      for (int r = 1; r < NREG; r++) begin
        if (i_rd_addr[p*AW +: AW] == AW'(r)) begin
          o_rd_dat[p*XLEN +: XLEN] = regs_q[r];
          o_rd_busy[p]             = busy_q[r];
        end else begin
          o_rd_dat[p*XLEN +: XLEN] = o_rd_dat[p*XLEN +: XLEN];
          o_rd_busy[p]             = o_rd_busy[p];
        end
      end
`ifdef REG_FILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (rst && i_wr_en[w] && addr_ok(i_rd_addr[p*AW +: AW]) &&
            (i_wr_addr[w*AW +: AW] == i_rd_addr[p*AW +: AW])) begin
          o_rd_dat[p*XLEN +: XLEN] = i_wr_dat[w*XLEN +: XLEN];
          o_rd_busy[p]             = i_alloc_en && (i_alloc_addr == i_rd_addr[p*AW +: AW]);
        end else begin
          o_rd_dat[p*XLEN +: XLEN] = o_rd_dat[p*XLEN +: XLEN];
          o_rd_busy[p]             = o_rd_busy[p];
        end
      end
`endif
    end
  end

  assign o_busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default 32x32, 2R/2W).
module tb_reg_file_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic              clk;
  logic              rst;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_dat;
  logic [1:0]        rd_busy;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_dat;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic [NREG-1:0]   busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd_addr    (rd_addr),
    .o_rd_dat     (rd_dat),
    .o_rd_busy    (rd_busy),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_dat     (wr_dat),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .o_busy_vec   (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    alloc_en = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = a;
    wr_dat[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b0; rd_addr = '0; wr_en = 2'b00; wr_addr = '0; wr_dat = '0;
    alloc_en = 1'b0; alloc_addr = '0;
    // Writes and alloc during reset must be ignored.
    set_wr(0, 5'd4, 32'hCAFE_0001);
    alloc_en = 1'b1; alloc_addr = 5'd6;
    tick();
    tick();
    idle();
    rst = 1'b1;

    // 1: everything reads zero after reset
    for (int a = 0; a < NREG; a++) begin
      set_rd(5'(a), 5'(NREG - 1 - a));
      check_val("rst_rd0", {32'd0, rd_dat[31:0]}, 64'd0);
      check_val("rst_rd1", {32'd0, rd_dat[63:32]}, 64'd0);
      check_val("rst_busy", {62'd0, rd_busy}, 64'd0);
    end
    check_val("rst_busy_vec", {32'd0, busy_vec}, 64'd0);

    // 2: simple write, visible next cycle on both ports
    set_wr(0, 5'd5, 32'hDEAD_BEEF);
    tick(); idle();
    set_rd(5'd5, 5'd5);
    check_val("wr5_p0", {32'd0, rd_dat[31:0]}, 64'hDEAD_BEEF);
    check_val("wr5_p1", {32'd0, rd_dat[63:32]}, 64'hDEAD_BEEF);

    // 3: x0 is hardwired
    set_wr(0, 5'd0, 32'h0000_1234);
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick(); idle();
    set_rd(5'd0, 5'd5);
    check_val("x0_rd", {32'd0, rd_dat[31:0]}, 64'd0);
    check_val("x0_busy_vec", {32'd0, busy_vec}, 64'd0);

    // 4: same-address collision, higher port wins
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    tick(); idle();
    set_rd(5'd7, 5'd7);
    check_val("x7_prio", {32'd0, rd_dat[31:0]}, 64'h22);

    // Distinct addresses on both ports land independently
    set_wr(0, 5'd10, 32'hA0A0_A0A0);
    set_wr(1, 5'd11, 32'hB1B1_B1B1);
    tick(); idle();
    set_rd(5'd10, 5'd11);
    check_val("dual_p0", {32'd0, rd_dat[31:0]}, 64'hA0A0_A0A0);
    check_val("dual_p1", {32'd0, rd_dat[63:32]}, 64'hB1B1_B1B1);

    // 5: scoreboard
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick(); idle();
    set_rd(5'd9, 5'd5);
    check_val("x9_busy", {62'd0, rd_busy}, 64'd1);
    check_val("x9_busy_vec", {32'd0, busy_vec}, 64'h0000_0200);
    set_wr(0, 5'd9, 32'h55);
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick(); idle();
    set_rd(5'd9, 5'd9);
    check_val("x9_alloc_wins", {62'd0, rd_busy}, 64'd3);
    check_val("x9_dat55", {32'd0, rd_dat[31:0]}, 64'h55);
    set_wr(1, 5'd9, 32'hAA);
    tick(); idle();
    set_rd(5'd9, 5'd9);
    check_val("x9_cleared", {62'd0, rd_busy}, 64'd0);
    check_val("x9_datAA", {32'd0, rd_dat[63:32]}, 64'hAA);

    // Re-alloc of an already busy register keeps it busy
    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick();
    tick(); idle();
    check_val("x4_realloc", {32'd0, busy_vec}, 64'h0000_0010);
    set_wr(0, 5'd4, 32'h4444);
    tick(); idle();
    check_val("x4_clear", {32'd0, busy_vec}, 64'd0);

    // 6: write and read the same register in one cycle
    set_wr(0, 5'd3, 32'h77);
    set_rd(5'd3, 5'd3);
`ifdef REG_FILE_BYPASS_EN
    check_val("x3_same_cycle", {32'd0, rd_dat[31:0]}, 64'h77);
`else
    check_val("x3_same_cycle", {32'd0, rd_dat[31:0]}, 64'd0);
`endif
    tick(); idle();
    set_rd(5'd3, 5'd3);
    check_val("x3_next", {32'd0, rd_dat[63:32]}, 64'h77);

    // Reset mid-operation beats a concurrent write and alloc
    rst = 1'b0;
    set_wr(0, 5'd3, 32'h99);
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick(); idle();
    rst = 1'b1;
    set_rd(5'd3, 5'd5);
    check_val("x3_after_rst", {32'd0, rd_dat[31:0]}, 64'd0);
    check_val("x5_after_rst", {32'd0, rd_dat[63:32]}, 64'd0);
    check_val("busy_after_rst", {32'd0, busy_vec}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
